// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared types and constants for the BCD-to-binary converter.
package bcd2bin_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX    = 4'd9;
    localparam bcd_t BCD_ADJ_TH = 4'd8;
endpackage

// File: rtl/bcd2bin_seq_adj.sv
// bcd_digit_adj: reverse double-dabble correction, subtract 3 from a digit of 8 or more.
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= BCD_ADJ_TH) ? d - 4'd3 : d;
endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential 3-digit BCD to binary converter (reverse double-dabble).
// Define BCD2BIN_ERR_EN to flag digits above 9 with err and a one-edge early DONE.
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int BIN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       bcd0,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd2,
    output logic             busy,
    output logic             valid,
    output logic [BIN_W-1:0] bin,
    output logic             err
);
    localparam int CW = $clog2(BIN_W + 1);

    state_t           state, nxt;
    logic [11:0]      sr, sh;
    logic [BIN_W-1:0] acc, acc_sh;
    logic [CW-1:0]    cnt;
    bcd_t             a0, a1, a2;
    logic             bad, last, cap;

`ifdef BCD2BIN_ERR_EN
    assign bad = (bcd0 > BCD_MAX) || (bcd1 > BCD_MAX) || (bcd2 > BCD_MAX);
`else
    assign bad = 1'b0;
`endif

    assign cap    = (state == IDLE) && start;
    assign last   = cnt == CW'(BIN_W - 1);
    assign sh     = {1'b0, sr[11:1]};
    assign acc_sh = {sr[0], acc[BIN_W-1:1]};
    assign busy   = state != IDLE;
    assign valid  = state == DONE;

    bcd_digit_adj u_adj0 (.d(sh[3:0]),  .q(a0));
    bcd_digit_adj u_adj1 (.d(sh[7:4]),  .q(a1));
    bcd_digit_adj u_adj2 (.d(sh[11:8]), .q(a2));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt = state;
        if (cap)                          nxt = bad ? DONE : SHIFT;
        else if (state == SHIFT && last)  nxt = DONE;
        else if (state == DONE)           nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sr  <= '0;
            acc <= '0;
            cnt <= '0;
            bin <= '0;
        end else if (cap) begin
            sr  <= {bcd2, bcd1, bcd0};
            acc <= '0;
            cnt <= '0;
            if (bad) bin <= '0;
        end else if (state == SHIFT) begin
            sr  <= {a2, a1, a0};
            acc <= acc_sh;
            cnt <= cnt + CW'(1);
            if (last) bin <= acc_sh;
        end

`ifdef BCD2BIN_ERR_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                     err <= 1'b0;
        else if (cap && bad)            err <= 1'b1;
        else if (state == SHIFT && last) err <= 1'b0;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: self-checking bench for bcd2bin_seq against an arithmetic reference.
module tb_bcd2bin_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  bcd0 = '0, bcd1 = '0, bcd2 = '0;
    logic        busy, valid, err;
    logic [11:0] bin;

    int nvec = 0;
    int nerr = 0;

    typedef struct {int d2; int d1; int d0; int exp;} vec_t;
    vec_t tbl[6];

    bcd2bin_seq #(.BIN_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2),
        .busy(busy), .valid(valid), .bin(bin), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int ref_bin(input int d2, input int d1, input int d0);
        return 100 * d2 + 10 * d1 + d0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge; drives a request and follows it to completion.
    task automatic convert(input int d2, input int d1, input int d0,
                           input int exp_bin, input int exp_err, input int exp_lat);
        int k;
        start = 1'b1;
        bcd2 = d2[3:0];
        bcd1 = d1[3:0];
        bcd0 = d0[3:0];
        @(negedge clk);
        k = 1;
        start = 1'b0;
        bcd2 = 4'($urandom);
        bcd1 = 4'($urandom);
        bcd0 = 4'($urandom);
        chk("busy_after_start", int'(busy), 1);
        while (!valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, exp_lat);
        chk("bin", int'(bin), exp_bin);
        chk("err", int'(err), exp_err);
        @(negedge clk);
        chk("valid_single", int'(valid), 0);
        chk("busy_end", int'(busy), 0);
        chk("bin_hold", int'(bin), exp_bin);
    endtask

    initial begin
        int q[$];
        int nval;
        int d2, d1, d0;

        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{9, 9, 9, 999};
        tbl[2] = '{1, 2, 3, 123};
        tbl[3] = '{0, 5, 0, 50};
        tbl[4] = '{1, 0, 3, 103};
        tbl[5] = '{9, 0, 9, 909};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_bin", int'(bin), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            convert(tbl[i].d2, tbl[i].d1, tbl[i].d0,
                    ref_bin(tbl[i].d2, tbl[i].d1, tbl[i].d0), 0, 13);

        for (int i = 0; i < 50; i++) begin
            d2 = $urandom_range(9);
            d1 = $urandom_range(9);
            d0 = $urandom_range(9);
            convert(d2, d1, d0, ref_bin(d2, d1, d0), 0, 13);
        end

        // start held high: captures every 14 cycles, digits change each cycle
        nval = 0;
        for (int c = 0; c < 42; c++) begin
            if (valid) begin
                nval++;
                if (q.size() == 0) chk("held_extra_valid", 1, 0);
                else chk("held_bin", int'(bin), q.pop_front());
            end
            d2 = $urandom_range(9);
            d1 = $urandom_range(9);
            d0 = $urandom_range(9);
            start = 1'b1;
            bcd2 = 4'(d2);
            bcd1 = 4'(d1);
            bcd0 = 4'(d0);
            if (c % 14 == 0) q.push_back(ref_bin(d2, d1, d0));
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_valid_count", nval, 3);
        chk("held_idle", int'(busy), 0);
        @(negedge clk);

        // reset during the 6th shift cycle of 4,5,6
        start = 1'b1;
        bcd2 = 4'd4; bcd1 = 4'd5; bcd0 = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_bin", int'(bin), 0);
        chk("abort_err", int'(err), 0);
        nval = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) nval++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (valid) nval++;
        end
        chk("abort_no_valid", nval, 0);
        convert(7, 8, 9, 789, 0, 13);

`ifdef BCD2BIN_ERR_EN
        convert(1, 10, 3, 0, 1, 1);
        convert(1, 0, 3, 103, 0, 13);
        convert(15, 0, 0, 0, 1, 1);
`endif

        for (int v = 0; v < 1000; v++)
            convert(v / 100, (v / 10) % 10, v % 10, v, 0, 13);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
